// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - constants and state encoding shared by the UART transmitter and receiver
package uart_pkg;

  localparam int DBIT_DEFAULT = 32;
  localparam int OVS          = 16;
  localparam int MID_START    = OVS / 2 - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_t;

endpackage

// File: rtl/uart_rx32_if.sv
// rtl/uart_rx32_if.sv - serial input, baud tick and received-word handshake of the receiver
interface uart_rx32_if #(
  parameter int DBIT = 32
) ();

  logic            s_tick;
  logic            rx;
  logic            rd_uart;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            rx_valid;
  logic            frame_err;
  logic            overrun_err;

  modport master (
    output s_tick, rx, rd_uart,
    input  dout, rx_done_tick, rx_valid, frame_err, overrun_err
  );

  modport slave (
    input  s_tick, rx, rd_uart,
    output dout, rx_done_tick, rx_valid, frame_err, overrun_err
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer that powers up to the idle-high line level
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx32.sv
// rtl/uart_rx32.sv - 16x oversampled UART receiver with hold-until-read word output
module uart_rx32
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = OVS
) (
  input  logic        clk,
  input  logic        reset,
  uart_rx32_if.slave  bus
);

  localparam int NW = ($clog2(DBIT) > 5) ? $clog2(DBIT) : 5;

  uart_state_t     state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      s                <= '0;
      n                <= '0;
      b                <= '0;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.rx_valid     <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.overrun_err  <= 1'b0;
    end else begin
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.overrun_err  <= 1'b0;
      if (bus.rd_uart) bus.rx_valid <= 1'b0;

      case (state)
        // Start edge is checked every clock so back-to-back frames lose no time.
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s     <= '0;
          end
        end
        ST_START: begin
          if (bus.s_tick) begin
            if (s == 5'(MID_START)) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (bus.s_tick) begin
            if (s == 5'(OVS - 1)) begin
              // Shift-and-or keeps this legal for a single-bit word.
              b <= (b >> 1) | (DBIT'(rx_s) << (DBIT - 1));
              s <= '0;
              if (n == NW'(DBIT - 1)) state <= ST_STOP;
              else                    n     <= n + NW'(1);
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        ST_STOP: begin
          if (bus.s_tick) begin
            if (s == 5'(SB_TICK - 1)) begin
              state <= ST_IDLE;
              s     <= '0;
              if (rx_s) begin
                bus.dout         <= b;
                bus.rx_done_tick <= 1'b1;
                bus.rx_valid     <= 1'b1;
                bus.overrun_err  <= bus.rx_valid & ~bus.rd_uart;
              end else begin
                bus.frame_err <= 1'b1;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx32.sv
// tb/tb_uart_rx32.sv - directed bench for uart_rx32 with 1 and 2 stop-bit instances
module tb_uart_rx32;

  localparam int M_OK      = 0;
  localparam int M_BADSTOP = 1;
  localparam int M_RD      = 2;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic s_tick  = 1'b0;
  logic rx      = 1'b1;
  logic rd_uart = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int tick_ph     = 0;
  int done_a = 0, ferr_a = 0, ovr_a = 0;
  int done_b = 0, ferr_b = 0;

  uart_rx32_if #(.DBIT(32)) bus_a ();
  uart_rx32_if #(.DBIT(32)) bus_b ();

  assign bus_a.s_tick  = s_tick;
  assign bus_a.rx      = rx;
  assign bus_a.rd_uart = rd_uart;
  assign bus_b.s_tick  = s_tick;
  assign bus_b.rx      = rx;
  assign bus_b.rd_uart = rd_uart;

  uart_rx32 #(.DBIT(32), .SB_TICK(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  uart_rx32 #(.DBIT(32), .SB_TICK(32)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_ph <= (tick_ph == 3) ? 0 : tick_ph + 1;
    s_tick  <= (tick_ph == 3);
  end

  always @(negedge clk) begin
    if (bus_a.rx_done_tick) done_a <= done_a + 1;
    if (bus_a.frame_err)    ferr_a <= ferr_a + 1;
    if (bus_a.overrun_err)  ovr_a  <= ovr_a + 1;
    if (bus_b.rx_done_tick) done_b <= done_b + 1;
    if (bus_b.frame_err)    ferr_b <= ferr_b + 1;
  end

  task automatic align();
    @(posedge clk iff s_tick);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int nt);
    repeat (nt) @(posedge clk iff s_tick);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int nt);
    rx = v;
    wait_ticks(nt);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  // Sender starts aligned just after a tick; receiver decides the stop bit on its 8th tick.
  task automatic send_frame(input logic [31:0] w, input int stop_ticks, input int mode);
    send_bit(1'b0, 16);
    for (int i = 0; i < 32; i++) send_bit(w[i], 16);
    if (mode == M_RD) begin
      rx = 1'b1;
      repeat (7) @(posedge clk iff s_tick);
      repeat (4) @(negedge clk);
      rd_uart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_uart = 1'b0;
      send_bit(1'b1, stop_ticks - 8);
    end else if (mode == M_BADSTOP) begin
      send_bit(1'b0, 8);
      send_bit(1'b1, stop_ticks - 8);
    end else begin
      send_bit(1'b1, stop_ticks);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_a.dout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dout got=%h exp=%h", bus_a.dout, 32'h0);
    end
    vectors++;
    if ({bus_a.rx_valid, bus_a.rx_done_tick, bus_a.frame_err, bus_a.overrun_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=%b",
               {bus_a.rx_valid, bus_a.rx_done_tick, bus_a.frame_err, bus_a.overrun_err}, 4'b0000);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0, f0, o0;
    align();
    d0 = done_a; f0 = ferr_a; o0 = ovr_a;
    send_frame(32'hA5C3_1E7F, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (done_a - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done_count got=%0d exp=%0d", done_a - d0, 1);
    end
    vectors++;
    if (bus_a.dout !== 32'hA5C3_1E7F) begin
      miscompares++;
      $display("FAIL basic_dout got=%h exp=%h", bus_a.dout, 32'hA5C3_1E7F);
    end
    vectors++;
    if (bus_a.rx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_valid got=%b exp=%b", bus_a.rx_valid, 1'b1);
    end
    vectors++;
    if ((ferr_a - f0) + (ovr_a - o0) !== 0) begin
      miscompares++;
      $display("FAIL basic_err_count got=%0d exp=%0d", (ferr_a - f0) + (ovr_a - o0), 0);
    end
    pulse_rd();
    vectors++;
    if (bus_a.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_clears_valid got=%b exp=%b", bus_a.rx_valid, 1'b0);
    end
  endtask

  task automatic test_glitch();
    int d0, f0;
    align();
    d0 = done_a; f0 = ferr_a;
    send_bit(1'b0, 5);
    send_bit(1'b1, 20);
    vectors++;
    if ((done_a - d0) + (ferr_a - f0) !== 0) begin
      miscompares++;
      $display("FAIL glitch_pulses got=%0d exp=%0d", (done_a - d0) + (ferr_a - f0), 0);
    end
    send_frame(32'h0000_0001, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (done_a - d0 !== 1) begin
      miscompares++;
      $display("FAIL glitch_next_done got=%0d exp=%0d", done_a - d0, 1);
    end
    vectors++;
    if (bus_a.dout !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL glitch_next_dout got=%h exp=%h", bus_a.dout, 32'h0000_0001);
    end
  endtask

  task automatic test_frame_err();
    int d0, f0;
    pulse_rd();
    align();
    d0 = done_a; f0 = ferr_a;
    send_frame(32'h1234_5678, 16, M_BADSTOP);
    wait_ticks(4);
    vectors++;
    if (ferr_a - f0 !== 1) begin
      miscompares++;
      $display("FAIL ferr_count got=%0d exp=%0d", ferr_a - f0, 1);
    end
    vectors++;
    if (done_a - d0 !== 0) begin
      miscompares++;
      $display("FAIL ferr_done_count got=%0d exp=%0d", done_a - d0, 0);
    end
    vectors++;
    if (bus_a.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_valid got=%b exp=%b", bus_a.rx_valid, 1'b0);
    end
    vectors++;
    if (bus_a.dout !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL ferr_dout_kept got=%h exp=%h", bus_a.dout, 32'h0000_0001);
    end
  endtask

  task automatic test_break();
    int d0, f0;
    align();
    d0 = done_a; f0 = ferr_a;
    // Two full attempts fail on the stop bit; the third sees the line high at mid-start.
    send_bit(1'b0, 1076);
    send_bit(1'b1, 30);
    vectors++;
    if (ferr_a - f0 !== 2) begin
      miscompares++;
      $display("FAIL break_ferr_count got=%0d exp=%0d", ferr_a - f0, 2);
    end
    vectors++;
    if (done_a - d0 !== 0) begin
      miscompares++;
      $display("FAIL break_done_count got=%0d exp=%0d", done_a - d0, 0);
    end
    send_frame(32'h5A5A_0F0F, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (bus_a.dout !== 32'h5A5A_0F0F || done_a - d0 !== 1) begin
      miscompares++;
      $display("FAIL break_recover got=%h/%0d exp=%h/%0d", bus_a.dout, done_a - d0, 32'h5A5A_0F0F, 1);
    end
  endtask

  task automatic test_overrun();
    int d0, o0;
    pulse_rd();
    align();
    d0 = done_a; o0 = ovr_a;
    send_frame(32'h1111_1111, 16, M_OK);
    send_frame(32'h2222_2222, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (ovr_a - o0 !== 1) begin
      miscompares++;
      $display("FAIL ovr_count got=%0d exp=%0d", ovr_a - o0, 1);
    end
    vectors++;
    if (bus_a.dout !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL ovr_dout got=%h exp=%h", bus_a.dout, 32'h2222_2222);
    end
    vectors++;
    if (bus_a.rx_valid !== 1'b1 || done_a - d0 !== 2) begin
      miscompares++;
      $display("FAIL ovr_valid_done got=%b/%0d exp=%b/%0d", bus_a.rx_valid, done_a - d0, 1'b1, 2);
    end
    align();
    o0 = ovr_a;
    send_frame(32'h3333_3333, 16, M_RD);
    wait_ticks(4);
    vectors++;
    if (ovr_a - o0 !== 0) begin
      miscompares++;
      $display("FAIL rd_at_load_ovr got=%0d exp=%0d", ovr_a - o0, 0);
    end
    vectors++;
    if (bus_a.rx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_at_load_valid got=%b exp=%b", bus_a.rx_valid, 1'b1);
    end
    vectors++;
    if (bus_a.dout !== 32'h3333_3333) begin
      miscompares++;
      $display("FAIL rd_at_load_dout got=%h exp=%h", bus_a.dout, 32'h3333_3333);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    int d0, f0;
    w = 32'hDEAD_BEEF;
    align();
    send_bit(1'b0, 16);
    for (int i = 0; i < 17; i++) send_bit(w[i], 16);
    send_bit(w[17], 8);
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus_a.dout, bus_a.rx_valid, bus_a.rx_done_tick, bus_a.frame_err, bus_a.overrun_err} !== 36'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%h/%b exp=%h/%b", bus_a.dout,
               {bus_a.rx_valid, bus_a.rx_done_tick, bus_a.frame_err, bus_a.overrun_err}, 32'h0, 4'b0000);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(4);
    d0 = done_a; f0 = ferr_a;
    send_frame(32'hCAFE_F00D, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (bus_a.dout !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL midreset_next_dout got=%h exp=%h", bus_a.dout, 32'hCAFE_F00D);
    end
    vectors++;
    if (done_a - d0 !== 1 || ferr_a - f0 !== 0) begin
      miscompares++;
      $display("FAIL midreset_next_pulses got=%0d/%0d exp=%0d/%0d", done_a - d0, ferr_a - f0, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, f0;
    align();
    d0 = done_a; f0 = ferr_a;
    send_frame(32'hFFFF_FFFF, 16, M_OK);
    send_frame(32'h0000_0000, 16, M_OK);
    wait_ticks(4);
    vectors++;
    if (done_a - d0 !== 2 || ferr_a - f0 !== 0) begin
      miscompares++;
      $display("FAIL b2b16_pulses got=%0d/%0d exp=%0d/%0d", done_a - d0, ferr_a - f0, 2, 0);
    end
    vectors++;
    if (bus_a.dout !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL b2b16_dout got=%h exp=%h", bus_a.dout, 32'h0000_0000);
    end
    // Let the 2-stop-bit instance settle after the short-stop traffic above.
    wait_ticks(600);
    align();
    d0 = done_b; f0 = ferr_b;
    send_frame(32'hFFFF_FFFF, 32, M_OK);
    send_frame(32'h0000_0000, 32, M_OK);
    wait_ticks(4);
    vectors++;
    if (done_b - d0 !== 2) begin
      miscompares++;
      $display("FAIL b2b32_done got=%0d exp=%0d", done_b - d0, 2);
    end
    vectors++;
    if (ferr_b - f0 !== 0) begin
      miscompares++;
      $display("FAIL b2b32_ferr got=%0d exp=%0d", ferr_b - f0, 0);
    end
    vectors++;
    if (bus_b.dout !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL b2b32_dout got=%h exp=%h", bus_b.dout, 32'h0000_0000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_break();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
